// File: rtl/systolic_array_db.sv
// Weight-stationary systolic tile with double-buffered column weights.
// Activations enter on the west edge (row r skewed by r cycles) and move east
// one PE per cycle with a valid tag; each PE multiplies by its column's active
// weight and accumulates. A tile FSM runs IDLE -> STREAM -> FLUSH -> DRAIN and
// drains the accumulators one row per handshake.
// Optional macro SYSTOLIC_SAT_EN: saturating accumulate instead of wrap-around.
module systolic_array_db #(
  parameter int unsigned N_ROWS = 8,
  parameter int unsigned N_COLS = 8,
  parameter int unsigned A_W    = 8,
  parameter int unsigned W_W    = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K_MAX  = 256,
  localparam int unsigned KW    = $clog2(K_MAX + 1),
  localparam int unsigned RW    = $clog2(N_ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [KW-1:0]           k_len,
  input  logic [N_ROWS-1:0]       row_en,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [N_COLS*W_W-1:0]   w_in_flat,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [N_ROWS*A_W-1:0]   a_in_flat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RW-1:0]           out_row,
  output logic                    out_last,
  output logic [N_COLS*ACC_W-1:0] out_flat,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StStream, StFlush, StDrain} state_e;

  localparam int unsigned   FW       = $clog2(N_ROWS + N_COLS);
  localparam logic [FW-1:0] FlushLen = FW'(N_ROWS + N_COLS - 1);
  localparam logic [RW-1:0] LastRow  = RW'(N_ROWS - 1);

  state_e                  state_q, state_d;
  logic [N_COLS*W_W-1:0]   shadow_w_q, active_w_q;
  logic                    shadow_full_q;
  logic [KW-1:0]           k_q, beat_cnt_q;
  logic [N_ROWS-1:0]       row_en_q;
  logic [FW-1:0]           flush_cnt_q;
  logic [RW-1:0]           out_row_q;
  logic                    start_fire, w_fire, a_fire, out_fire;

  logic [A_W-1:0]          row_a  [N_ROWS];
  logic [N_ROWS-1:0]       row_t;
  logic [A_W-1:0]          pipe_a [N_ROWS][N_COLS];
  logic [N_COLS-1:0]       pipe_t [N_ROWS];
  logic [ACC_W-1:0]        acc_q  [N_ROWS][N_COLS];

  // One multiply-accumulate step: signed product, sign-extended, wrap or clamp.
  function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0] acc,
                                           input logic [A_W-1:0]   a,
                                           input logic [W_W-1:0]   w);
    logic signed [A_W+W_W-1:0] prod;
`ifdef SYSTOLIC_SAT_EN
    logic signed [ACC_W:0] sum;
`endif
    prod = (A_W + W_W)'($signed(a)) * (A_W + W_W)'($signed(w));
`ifdef SYSTOLIC_SAT_EN
    sum = $signed({acc[ACC_W-1], acc}) + (ACC_W + 1)'(prod);
    // Top two bits disagree: the true sum left the ACC_W range.
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      return sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end
    return sum[ACC_W-1:0];
`else
    return acc + ACC_W'(prod);
`endif
  endfunction

  assign w_ready    = !shadow_full_q;
  assign start_fire = start_valid & start_ready;
  assign w_fire     = w_valid & w_ready;
  assign a_fire     = a_valid & a_ready;
  assign out_fire   = out_valid & out_ready;
  assign out_row    = out_row_q;
  assign out_last   = (out_row_q == LastRow);

  // Tile FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Tile FSM next state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    a_ready     = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy        = 1'b0;
        start_ready = shadow_full_q;
        if (start_valid && shadow_full_q) begin
          state_d = (k_len == '0) ? StFlush : StStream;
        end
      end
      StStream: begin
        a_ready = 1'b1;
        if (a_valid && (beat_cnt_q + KW'(1)) == k_q) state_d = StFlush;
      end
      StFlush: begin
        if (flush_cnt_q == FW'(1)) state_d = StDrain;
      end
      StDrain: begin
        out_valid = 1'b1;
        if (out_ready && out_row_q == LastRow) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Weight banks, tile parameters and sequencing counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_w_q    <= '0;
      active_w_q    <= '0;
      shadow_full_q <= 1'b0;
      k_q           <= '0;
      row_en_q      <= '0;
      beat_cnt_q    <= '0;
      flush_cnt_q   <= FlushLen;
      out_row_q     <= '0;
    end else begin
      if (w_fire) begin
        shadow_w_q    <= w_in_flat;
        shadow_full_q <= 1'b1;
      end
      if (start_fire) begin
        active_w_q    <= shadow_w_q;
        shadow_full_q <= 1'b0;
        k_q           <= k_len;
        row_en_q      <= row_en;
        beat_cnt_q    <= '0;
      end else if (a_fire) begin
        beat_cnt_q <= beat_cnt_q + KW'(1);
      end
      // Held at full length outside FLUSH so it is armed on entry.
      flush_cnt_q <= (state_q == StFlush) ? flush_cnt_q - FW'(1) : FlushLen;
      if (out_fire) out_row_q <= out_last ? '0 : out_row_q + RW'(1);
    end
  end

  // Input skew: row r is delayed r cycles before entering column 0.
  for (genvar r = 0; r < N_ROWS; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign row_a[r] = a_in_flat[0 +: A_W];
      assign row_t[r] = a_fire;
    end else begin : g_delay
      logic [A_W-1:0] sk_a [r];
      logic [r-1:0]   sk_t;

      // Shift the row's data and tag through its skew stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) sk_a[i] <= '0;
          sk_t <= '0;
        end else begin
          sk_a[0] <= a_in_flat[r*A_W +: A_W];
          sk_t[0] <= a_fire;
          for (int i = 1; i < r; i++) begin
            sk_a[i] <= sk_a[i-1];
            sk_t[i] <= sk_t[i-1];
          end
        end
      end

      assign row_a[r] = sk_a[r-1];
      assign row_t[r] = sk_t[r-1];
    end
  end

  // PE grid: move data east each cycle and accumulate tagged beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_ROWS; r++) begin
        pipe_t[r] <= '0;
        for (int c = 0; c < N_COLS; c++) begin
          pipe_a[r][c] <= '0;
          acc_q[r][c]  <= '0;
        end
      end
    end else begin
      for (int r = 0; r < N_ROWS; r++) begin
        pipe_a[r][0] <= row_a[r];
        pipe_t[r][0] <= row_t[r];
        for (int c = 1; c < N_COLS; c++) begin
          pipe_a[r][c] <= pipe_a[r][c-1];
          pipe_t[r][c] <= pipe_t[r][c-1];
        end
        for (int c = 0; c < N_COLS; c++) begin
          if (start_fire) begin
            acc_q[r][c] <= '0;
          end else if (pipe_t[r][c] && row_en_q[r]) begin
            acc_q[r][c] <= mac(acc_q[r][c], pipe_a[r][c], active_w_q[c*W_W +: W_W]);
          end
        end
      end
    end
  end

  // Present the accumulators of the selected drain row.
  always_comb begin
    out_flat = '0;
    for (int c = 0; c < N_COLS; c++) out_flat[c*ACC_W +: ACC_W] = acc_q[out_row_q][c];
  end

endmodule
